alu_dsp48: RTL and testbench
============================

Name: alu_dsp48

Overview:
- Pipelined 16-bit ALU slice behaviourally modelling a DSP48E2 used in logic/add/sub mode (no multiplier).
- Supports AND, OR, XOR, ADD, ADD-with-carry and SUB, selected by DSP-style OPMODE/ALUMODE codes.
- Supports SEQ, SLTU and SLTS compares, derived from the subtract result by post-logic selected with setinst.
- Sits in the core's execute stage.
- A valid bit travels alongside the data with identical latency.

Parameters:
- WIDTH, 16, operand/result width; compare logic uses a WIDTH+1-bit internal difference.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in0  in  WIDTH  operand routed to the Z/C path (minuend).
- in1  in  WIDTH  operand routed to the X/A:B path (subtrahend).
- carryin  in  1  CIN for add/sub.
- opmode  in  9  DSP OPMODE: [1:0] X, [3:2] Y, [6:4] Z, [8:7] W.
- alumode  in  4  DSP ALUMODE.
- setinst  in  2  post-op select: 00 none, 01 SEQ, 10 SLTU, 11 SLTS.
- valid_in  in  1  operand valid.
- out  out  WIDTH  result.
- carryout  out  1  carry/borrow flag.
- valid_out  out  1  out/carryout valid.

Behaviour:
- Reset: all pipeline registers clear to 0; out=0, carryout=0, valid_out=0.
- Stage 1 (input regs) captures in0, in1, carryin, opmode, alumode, setinst and valid_in every edge. No enable; valid only qualifies.
- Stage 2 (P reg) captures the computed result, carryout and the stage-1 valid.
- Latency: inputs driven in cycle c are sampled at the end of c; out/valid_out show the result during cycle c+2. Full throughput, one op per cycle.
- Mux decode:
  - X: 00 -> 0, 11 -> in1, others -> 0.
  - Y: 00 -> 0, 10 -> all-ones, others -> 0.
  - Z: 000 -> 0, 011 -> in0, others -> 0.
  - W: always 0.
- ALUMODE 0000: P = Z+W+X+Y+CIN, computed WIDTH+1 wide. out = low WIDTH bits; carryout = bit WIDTH.
- ALUMODE 0011: P = Z-(W+X+Y+CIN). out = low WIDTH bits, wrapping mod 2^WIDTH; carryout = 1 iff a borrow occurred.
- ALUMODE 1100: Y=00 -> X AND Z; Y=10 -> X OR Z.
- ALUMODE 0100: Y=00 -> X XOR Z; Y=10 -> X XNOR Z.
- Logic ops force carryout=0.
- Any other ALUMODE: out=0, carryout=0.
- setinst != 00 replaces out with {WIDTH-1 zeros, flag}; carryout keeps its arithmetic value. Flag:
  - SEQ: difference == 0.
  - SLTU: borrow (in0 < in1 unsigned).
  - SLTS: sign(diff) XOR signed-overflow (in0 < in1 signed).
- setinst is honoured only with ALUMODE 0011 and carryin=0; otherwise out=0.
- Reset mid-stream drops in-flight ops: valid_out=0 in the two cycles after reset deassertion.

Optional Feature:
- Macro: ALU_DSP48_OUT_GATE_EN.
- Defined: out and carryout are forced to 0 whenever valid_out=0.
- Undefined: out/carryout reflect whatever stage 2 holds, including results of invalid slots.

Decomposition:
- Package alu_dsp48_pkg holds:
  - OPMODE constants: OPM_XZ=9'b000110011, OPM_XZ_YONES=9'b000111011.
  - ALUMODE constants: ADD=0000, SUB=0011, XOR=0100, AND_OR=1100.
  - setinst enum: NONE, SEQ, SLTU, SLTS.
- One sub-module, alu_dsp48_setlogic: combinational compare flags from the WIDTH+1 difference and operand MSBs.

Test Plan:
- AND: opmode 000110011, alumode 1100, in0=0xF0F0, in1=0x3C3C, valid_in=1 -> two cycles later valid_out=1, out=0x3030.
- OR/XOR:
  - opmode 000111011, alumode 1100, in0=0x00FF, in1=0x0F00 -> out=0x0FFF.
  - opmode 000110011, alumode 0100, in0=0xFFFF, in1=0x1234 -> out=0xEDCB.
- ADD with carry: alumode 0000, in0=0xFFFF, in1=0x0001, carryin=1 -> out=0x0001, carryout=1.
- SUB wrap: alumode 0011, in0=0x0001, in1=0x0002 -> out=0xFFFF, carryout=1.
- Compares (alumode 0011):
  - SEQ, in0=in1=5 -> out=1.
  - SLTU, in0=0x0001, in1=0x8000 -> out=1.
  - SLTS, same operands -> out=0.
  - SLTS, in0=0x8000, in1=0x0001 -> out=1.
- Pipeline/reset:
  - Random 500 ops with random valid_in gaps -> every valid_out matches the model 2 cycles later.
  - Assert reset with ops in flight -> valid_out=0, out=0 next cycle.

Source files
------------

// File: rtl/alu_dsp48_pkg.sv
// alu_dsp48_pkg: shared constants and types for the alu_dsp48 slice.
//   OPM_*   : OPMODE words for the two supported mux settings
//   ALUM_*  : ALUMODE codes (add, subtract, xor/xnor, and/or)
//   setinst_t : post-op compare select applied to the subtract result
package alu_dsp48_pkg;

    localparam logic [8:0] OPM_XZ       = 9'b000110011;
    localparam logic [8:0] OPM_XZ_YONES = 9'b000111011;

    localparam logic [3:0] ALUM_ADD    = 4'b0000;
    localparam logic [3:0] ALUM_SUB    = 4'b0011;
    localparam logic [3:0] ALUM_XOR    = 4'b0100;
    localparam logic [3:0] ALUM_AND_OR = 4'b1100;

    typedef enum logic [1:0] {
        SET_NONE = 2'b00,
        SET_SEQ  = 2'b01,
        SET_SLTU = 2'b10,
        SET_SLTS = 2'b11
    } setinst_t;

endpackage

// File: rtl/alu_dsp48_setlogic.sv
// alu_dsp48_setlogic: combinational compare flag generator.
//   diff    in  WIDTH+1  {0,a} - {0,b}; bit WIDTH is the unsigned borrow
//   a_msb   in  1        sign bit of the minuend
//   b_msb   in  1        sign bit of the subtrahend
//   setinst in  2        compare select (none, SEQ, SLTU, SLTS)
//   flag    out 1        selected compare result
module alu_dsp48_setlogic
    import alu_dsp48_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] diff,
    input  logic           a_msb,
    input  logic           b_msb,
    input  setinst_t       setinst,
    output logic           flag
);

    logic ovf;

    // Signed overflow: operands differ in sign and the result sign differs from the minuend.
    assign ovf = (a_msb ^ b_msb) & (diff[WIDTH-1] ^ a_msb);

    always_comb begin
        flag = 1'b0;
        case (setinst)
            SET_SEQ:  flag = (diff == '0);
            SET_SLTU: flag = diff[WIDTH];
            SET_SLTS: flag = diff[WIDTH-1] ^ ovf;
            default:  flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_dsp48.sv
// alu_dsp48: two-stage pipelined logic/add/sub ALU slice in DSP48E2 style.
//   clock     in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset, clears every register
//   in0       in  WIDTH  Z-path operand (minuend)
//   in1       in  WIDTH  X-path operand (subtrahend)
//   carryin   in  1      CIN
//   opmode    in  9      X[1:0] Y[3:2] Z[6:4] W[8:7] mux selects
//   alumode   in  4      ALU function
//   setinst   in  2      compare select applied to the subtract result
//   valid_in  in  1      operand valid, travels with the data
//   out       out WIDTH  result (stage 2)
//   carryout  out 1      carry / borrow (stage 2)
//   valid_out out 1      result valid
// Build option: define ALU_DSP48_OUT_GATE_EN to force out/carryout to 0 while
// valid_out is low; otherwise they show whatever stage 2 holds.
module alu_dsp48
    import alu_dsp48_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             carryin,
    input  logic [8:0]       opmode,
    input  logic [3:0]       alumode,
    input  logic [1:0]       setinst,
    input  logic             valid_in,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             valid_out
);

    logic [WIDTH-1:0] s1_in0, s1_in1;
    logic             s1_cin, s1_valid;
    logic [8:0]       s1_opmode;
    logic [3:0]       s1_alumode;
    setinst_t         s1_setinst;

    logic [WIDTH-1:0] p_out;
    logic             p_carry, p_valid;

    logic [WIDTH-1:0] x, y, z, w;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH+1:0] sub_term;
    logic [WIDTH-1:0] sub_res;
    logic             borrow;
    logic [WIDTH:0]   cmp_diff;
    logic             flag;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_in0     <= '0;
            s1_in1     <= '0;
            s1_cin     <= 1'b0;
            s1_opmode  <= '0;
            s1_alumode <= '0;
            s1_setinst <= SET_NONE;
            s1_valid   <= 1'b0;
        end else begin
            s1_in0     <= in0;
            s1_in1     <= in1;
            s1_cin     <= carryin;
            s1_opmode  <= opmode;
            s1_alumode <= alumode;
            s1_setinst <= setinst_t'(setinst);
            s1_valid   <= valid_in;
        end
    end

    assign x = (s1_opmode[1:0] == 2'b11)  ? s1_in1 : '0;
    assign y = (s1_opmode[3:2] == 2'b10)  ? '1     : '0;
    assign z = (s1_opmode[6:4] == 3'b011) ? s1_in0 : '0;
    // The W mux has no live source in this slice; every select yields zero.
    assign w = (s1_opmode[8:7] == 2'b00)  ? '0     : '0;

    assign sum_full = {1'b0, z} + {1'b0, w} + {1'b0, x} + {1'b0, y}
                    + {{WIDTH{1'b0}}, s1_cin};

    // Subtrahend kept two bits wider so the borrow is exact even when X+Y+CIN exceeds WIDTH bits.
    assign sub_term = {2'b00, w} + {2'b00, x} + {2'b00, y}
                    + {{(WIDTH+1){1'b0}}, s1_cin};
    assign sub_res  = z - sub_term[WIDTH-1:0];
    assign borrow   = ({2'b00, z} < sub_term);

    // Compares only run with CIN=0, so the subtrahend is X+Y reduced to WIDTH bits.
    assign cmp_diff = {1'b0, z} - {1'b0, sub_term[WIDTH-1:0]};

    alu_dsp48_setlogic #(
        .WIDTH (WIDTH)
    ) u_setlogic (
        .diff    (cmp_diff),
        .a_msb   (z[WIDTH-1]),
        .b_msb   (sub_term[WIDTH-1]),
        .setinst (s1_setinst),
        .flag    (flag)
    );

    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        case (s1_alumode)
            ALUM_ADD: begin
                res       = sum_full[WIDTH-1:0];
                res_carry = sum_full[WIDTH];
            end
            ALUM_SUB: begin
                res       = sub_res;
                res_carry = borrow;
            end
            ALUM_AND_OR: begin
                case (s1_opmode[3:2])
                    2'b00:   res = x & z;
                    2'b10:   res = x | z;
                    default: res = '0;
                endcase
            end
            ALUM_XOR: begin
                case (s1_opmode[3:2])
                    2'b00:   res = x ^ z;
                    2'b10:   res = ~(x ^ z);
                    default: res = '0;
                endcase
            end
            default: begin
                res       = '0;
                res_carry = 1'b0;
            end
        endcase
        if (s1_setinst != SET_NONE) begin
            if ((s1_alumode == ALUM_SUB) && !s1_cin) begin
                res = {{(WIDTH-1){1'b0}}, flag};
            end else begin
                res = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_out   <= '0;
            p_carry <= 1'b0;
            p_valid <= 1'b0;
        end else begin
            p_out   <= res;
            p_carry <= res_carry;
            p_valid <= s1_valid;
        end
    end

`ifdef ALU_DSP48_OUT_GATE_EN
    assign out      = p_valid ? p_out : '0;
    assign carryout = p_valid & p_carry;
`else
    assign out      = p_out;
    assign carryout = p_carry;
`endif
    assign valid_out = p_valid;

endmodule

// File: tb/tb_alu_dsp48.sv
module tb_alu_dsp48;
    import alu_dsp48_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in0, in1;
    logic        carryin;
    logic [8:0]  opmode;
    logic [3:0]  alumode;
    logic [1:0]  setinst;
    logic        valid_in;
    logic [15:0] out;
    logic        carryout;
    logic        valid_out;

    int checks   = 0;
    int failures = 0;

    alu_dsp48 #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in0       (in0),
        .in1       (in1),
        .carryin   (carryin),
        .opmode    (opmode),
        .alumode   (alumode),
        .setinst   (setinst),
        .valid_in  (valid_in),
        .out       (out),
        .carryout  (carryout),
        .valid_out (valid_out)
    );

    always #5 clock = ~clock;

    // Reference model: {carryout, out} from the operation rules using plain integers.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic [8:0] opm,
                                          input logic [3:0] alm, input logic [1:0] si);
        int x, y, z, t, r, c, sa, sb;
        logic f;
        x = (opm[1:0] == 2'b11)  ? int'(b) : 0;
        y = (opm[3:2] == 2'b10)  ? 65535   : 0;
        z = (opm[6:4] == 3'b011) ? int'(a) : 0;
        r = 0;
        c = 0;
        f = 1'b0;
        case (alm)
            4'b0000: begin
                t = z + x + y + int'(ci);
                r = t % 65536;
                c = (t / 65536) % 2;
            end
            4'b0011: begin
                t = x + y + int'(ci);
                r = (z - t) & 65535;
                c = (z < t) ? 1 : 0;
            end
            4'b1100: begin
                if (opm[3:2] == 2'b00) r = x & z;
                else if (opm[3:2] == 2'b10) r = x | z;
            end
            4'b0100: begin
                if (opm[3:2] == 2'b00) r = x ^ z;
                else if (opm[3:2] == 2'b10) r = (x ^ z) ^ 65535;
            end
            default: ;
        endcase
        if (si != 2'b00) begin
            if (alm == 4'b0011 && ci == 1'b0) begin
                t  = (x + y) % 65536;
                sa = (z >= 32768) ? z - 65536 : z;
                sb = (t >= 32768) ? t - 65536 : t;
                if (si == 2'b01)      f = (z == t);
                else if (si == 2'b10) f = (z < t);
                else                  f = (sa < sb);
                r = f ? 1 : 0;
            end else begin
                r = 0;
            end
        end
        return {c[0], r[15:0]};
    endfunction

    // Issues one valid op and returns what the outputs show two cycles later.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [8:0] opm, input logic [3:0] alm, input logic [1:0] si,
                          output logic [15:0] o, output logic co, output logic v);
        @(negedge clock);
        in0 = a; in1 = b; carryin = ci; opmode = opm; alumode = alm; setinst = si;
        valid_in = 1'b1;
        @(negedge clock);
        valid_in = 1'b0;
        @(negedge clock);
        o = out; co = carryout; v = valid_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in0 = '0; in1 = '0; carryin = 1'b0; opmode = '0; alumode = '0; setinst = '0;
        valid_in = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({valid_out, carryout, out} !== 18'h0) begin
            failures++;
            $display("FAIL reset_state: got v=%b c=%b out=%h expected 0 0 0000", valid_out, carryout, out);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_valid: got %b expected 0", valid_out);
        end
    endtask

    task automatic test_and();
        logic [15:0] o; logic co, v;
        run_op(16'hF0F0, 16'h3C3C, 1'b0, OPM_XZ, ALUM_AND_OR, 2'b00, o, co, v);
        checks++;
        if (v !== 1'b1) begin failures++; $display("FAIL and_valid: got %b expected 1", v); end
        checks++;
        if (o !== 16'h3030) begin failures++; $display("FAIL and_out: got %h expected 3030", o); end
    endtask

    task automatic test_or_xor();
        logic [15:0] o; logic co, v;
        run_op(16'h00FF, 16'h0F00, 1'b0, OPM_XZ_YONES, ALUM_AND_OR, 2'b00, o, co, v);
        checks++;
        if (o !== 16'h0FFF || co !== 1'b0) begin
            failures++; $display("FAIL or_out: got %h c=%b expected 0fff c=0", o, co);
        end
        run_op(16'hFFFF, 16'h1234, 1'b0, OPM_XZ, ALUM_XOR, 2'b00, o, co, v);
        checks++;
        if (o !== 16'hEDCB) begin failures++; $display("FAIL xor_out: got %h expected edcb", o); end
        run_op(16'hFFFF, 16'h1234, 1'b0, OPM_XZ_YONES, ALUM_XOR, 2'b00, o, co, v);
        checks++;
        if (o !== 16'h1234) begin failures++; $display("FAIL xnor_out: got %h expected 1234", o); end
    endtask

    task automatic test_add_carry();
        logic [15:0] o; logic co, v;
        run_op(16'hFFFF, 16'h0001, 1'b1, OPM_XZ, ALUM_ADD, 2'b00, o, co, v);
        checks++;
        if (o !== 16'h0001 || co !== 1'b1) begin
            failures++; $display("FAIL add_carry: got %h c=%b expected 0001 c=1", o, co);
        end
    endtask

    task automatic test_sub_wrap();
        logic [15:0] o; logic co, v;
        run_op(16'h0001, 16'h0002, 1'b0, OPM_XZ, ALUM_SUB, 2'b00, o, co, v);
        checks++;
        if (o !== 16'hFFFF || co !== 1'b1) begin
            failures++; $display("FAIL sub_wrap: got %h c=%b expected ffff c=1", o, co);
        end
        run_op(16'h0005, 16'h0002, 1'b0, OPM_XZ, ALUM_SUB, 2'b00, o, co, v);
        checks++;
        if (o !== 16'h0003 || co !== 1'b0) begin
            failures++; $display("FAIL sub_noborrow: got %h c=%b expected 0003 c=0", o, co);
        end
    endtask

    task automatic test_compares();
        logic [15:0] o; logic co, v;
        run_op(16'd5, 16'd5, 1'b0, OPM_XZ, ALUM_SUB, SET_SEQ, o, co, v);
        checks++;
        if (o !== 16'h0001) begin failures++; $display("FAIL seq_equal: got %h expected 0001", o); end
        run_op(16'h0001, 16'h8000, 1'b0, OPM_XZ, ALUM_SUB, SET_SLTU, o, co, v);
        checks++;
        if (o !== 16'h0001 || co !== 1'b1) begin
            failures++; $display("FAIL sltu_less: got %h c=%b expected 0001 c=1", o, co);
        end
        run_op(16'h0001, 16'h8000, 1'b0, OPM_XZ, ALUM_SUB, SET_SLTS, o, co, v);
        checks++;
        if (o !== 16'h0000) begin failures++; $display("FAIL slts_pos_vs_neg: got %h expected 0000", o); end
        run_op(16'h8000, 16'h0001, 1'b0, OPM_XZ, ALUM_SUB, SET_SLTS, o, co, v);
        checks++;
        if (o !== 16'h0001) begin failures++; $display("FAIL slts_neg_vs_pos: got %h expected 0001", o); end
        run_op(16'd5, 16'd5, 1'b1, OPM_XZ, ALUM_SUB, SET_SEQ, o, co, v);
        checks++;
        if (o !== 16'h0000) begin failures++; $display("FAIL seq_with_cin: got %h expected 0000", o); end
    endtask

    task automatic rand_inputs(input logic v);
        int sel;
        in0 = 16'($urandom);
        in1 = ($urandom_range(0, 7) == 0) ? in0 : 16'($urandom);
        carryin = ($urandom_range(0, 2) == 0);
        sel = $urandom_range(0, 3);
        opmode = (sel == 1) ? OPM_XZ_YONES : (sel == 2) ? 9'($urandom) : OPM_XZ;
        sel = $urandom_range(0, 5);
        case (sel)
            0:       alumode = ALUM_ADD;
            1:       alumode = ALUM_XOR;
            2:       alumode = ALUM_AND_OR;
            3:       alumode = 4'($urandom);
            default: alumode = ALUM_SUB;
        endcase
        setinst = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
        valid_in = v;
    endtask

    task automatic test_back_to_back_random();
        logic [16:0] exp_r [0:501];
        logic        exp_v [0:501];
        for (int i = 0; i < 502; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                checks++;
                if (valid_out !== exp_v[i-2]) begin
                    failures++;
                    $display("FAIL rand_valid[%0d]: got %b expected %b", i - 2, valid_out, exp_v[i-2]);
                end
                if (exp_v[i-2]) begin
                    checks++;
                    if ({carryout, out} !== exp_r[i-2]) begin
                        failures++;
                        $display("FAIL rand_result[%0d]: got c=%b out=%h expected c=%b out=%h",
                                 i - 2, carryout, out, exp_r[i-2][16], exp_r[i-2][15:0]);
                    end
                end else begin
`ifdef ALU_DSP48_OUT_GATE_EN
                    checks++;
                    if ({carryout, out} !== 17'h0) begin
                        failures++;
                        $display("FAIL rand_gated[%0d]: got c=%b out=%h expected 0", i - 2, carryout, out);
                    end
`endif
                end
            end
            rand_inputs($urandom_range(0, 3) != 0);
            exp_v[i] = valid_in;
            exp_r[i] = model(in0, in1, carryin, opmode, alumode, setinst);
        end
        @(negedge clock);
        valid_in = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [16:0] exp_a;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            rand_inputs(1'b1);
        end
        @(negedge clock);
        reset = 1'b1;
        rand_inputs(1'b1);
        @(negedge clock);
        checks++;
        if ({valid_out, carryout, out} !== 18'h0) begin
            failures++;
            $display("FAIL midreset_flush: got v=%b c=%b out=%h expected 0 0 0000", valid_out, carryout, out);
        end
        reset = 1'b0;
        rand_inputs(1'b1);
        exp_a = model(in0, in1, carryin, opmode, alumode, setinst);
        @(negedge clock);
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin
            failures++; $display("FAIL midreset_second_cycle: got valid %b expected 0", valid_out);
        end
        @(negedge clock);
        checks++;
        if (valid_out !== 1'b1 || {carryout, out} !== exp_a) begin
            failures++;
            $display("FAIL midreset_resume: got v=%b c=%b out=%h expected v=1 c=%b out=%h",
                     valid_out, carryout, out, exp_a[16], exp_a[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_or_xor();
        test_add_carry();
        test_sub_wrap();
        test_compares();
        test_back_to_back_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
